instruction_tl_arbiter: RTL and testbench
=========================================

Name: instruction_tl_arbiter

Overview:
Shares the single hart-0 instruction TileLink-UL port between two fetch requesters: requester 0 is the core fetch unit, requester 1 is the debug/trace fetch path.
- Round-robin arbitration on channel A; each Get is tagged with the requester index as the 1-bit `source`.
- Channel D beats are routed back to the owning requester by `source`; at most one outstanding Get per requester.
- Sits between the fetch requesters and the instruction TL bundle (A: Get out; D: AccessAckData in).

Parameters:
ADDR_W, 32, address width
DATA_W, 32, D data width; beat bytes = DATA_W/8, LG_BEAT = log2(DATA_W/8) = 2
MAX_SIZE, 6, largest legal lg2 transfer size (64 B = 16 beats)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
req_valid  in  2  per-requester Get request valid
req_ready  out  2  per-requester request accepted
req_address  in  2*ADDR_W  per-requester address, aligned to 2^size
req_size  in  2*4  per-requester lg2 bytes
rsp_valid  out  2  per-requester response beat valid
rsp_ready  in  2  per-requester response beat ready
rsp_data  out  DATA_W  shared response data (qualified by rsp_valid)
rsp_denied  out  1  shared denied flag
rsp_corrupt  out  1  shared corrupt flag
rsp_last  out  1  shared last-beat flag
tl_a_valid / tl_a_ready  out / in  1 / 1  channel A handshake
tl_a_opcode  out  3  always 3'd4 (Get)
tl_a_param  out  3  always 0
tl_a_size  out  4  lg2 transfer size
tl_a_source  out  1  index of the granted requester
tl_a_address  out  ADDR_W  transfer address
tl_a_mask  out  DATA_W/8  byte mask
tl_d_valid / tl_d_ready  in / out  1 / 1  channel D handshake
tl_d_opcode  in  3  response opcode
tl_d_param  in  2  response param
tl_d_size  in  4  response size
tl_d_source  in  1  response source
tl_d_sink  in  1  response sink (ignored)
tl_d_denied  in  1  denied flag
tl_d_corrupt  in  1  corrupt flag
tl_d_data  in  DATA_W  response data
protocol_err  out  1  sticky error flag, cleared only by reset

Behaviour:
Reset:
- Outputs `req_ready`, `rsp_valid`, `tl_a_valid`, `protocol_err` = 0.
- `outstanding[1:0]` = 0, round-robin pointer `rr` = 0, both beat counters = 0, grant unlocked.

Channel A:
- Eligible[i] = `req_valid[i]` && !`outstanding[i]`.
- When unlocked, grant the eligible requester, starting the search at `rr`.
- `tl_a_*` is driven combinationally from the granted requester.
- If `tl_a_valid` && !`tl_a_ready`, the grant locks and is held until the A fire; A contents must stay stable.
- A fire (`tl_a_valid` && `tl_a_ready`), in the same cycle:
  - `req_ready[g]` = 1;
  - set `outstanding[g]`;
  - load beat count = (size > LG_BEAT) ? (1 << (size - LG_BEAT)) - 1 : 0;
  - `rr` <= ~g.
- Mask generation:
  - size >= 2: all ones;
  - size 1: 4'b0011 << (2*addr[1]);
  - size 0: 1 << addr[1:0].
- A request with size > MAX_SIZE is still forwarded and sets `protocol_err`.

Channel D:
- s = `tl_d_source`.
- If `outstanding[s]`:
  - `rsp_valid[s]` = `tl_d_valid`; `tl_d_ready` = `rsp_ready[s]`; data, denied and corrupt pass through (zero latency).
  - `rsp_last` = (beat count[s] == 0).
- On each D fire, decrement beat count[s]; on the last-beat fire, clear `outstanding[s]`.
- A D beat with !`outstanding[s]` or opcode != 3'd1 (AccessAckData):
  - `tl_d_ready` = 1 (drained), no `rsp_valid`, `protocol_err` set.
- Denied: the response still spans the full beat count.

Simultaneous events:
- A fire for requester i and last-beat D fire for requester j≠i in the same cycle: both take effect.
- Same requester in the same cycle is impossible, because `outstanding` blocks eligibility.

Reset mid-transfer:
- All state clears.
- Stale D beats after reset hit the drain path and set `protocol_err`.

Optional Feature:
Macro: `INSTRUCTION_TL_ARBITER_PERF_EN`.
- Defined: adds outputs `perf_grant0`, `perf_grant1`, `perf_denied` (32 bits each).
  - `perf_grant0` / `perf_grant1` increment on A fire per requester; `perf_denied` increments on last-beat D fire with `tl_d_denied`.
  - All reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package `instruction_tl_pkg`:
  - localparams TL_OP_GET = 3'd4 and TL_OP_ACCESS_ACK_DATA = 3'd1, LG_BEAT;
  - function `tl_mask(size, addr_lo)`;
  - function `tl_beats_m1(size)`.
- Sub-module `instruction_tl_rr_arb2`: a 2-way round-robin arbiter with a lock input, used for the grant and the `rr` pointer.

Test Plan:
1. Req0 Get addr 0x8000_0000 size 2, `tl_a_ready`=1 -> opcode 4, source 0, mask 4'hF; D beat data 0xDEAD_BEEF -> `rsp_valid[0]`, `rsp_last`=1, `outstanding[0]` clears.
2. Both requesters valid continuously, all readys 1, responses immediate -> grants alternate 0,1,0,1; `rr` toggles.
3. Req1 size 6 -> 16 D beats; `rsp_last` only on beat 16; a req1 resubmit is blocked until after beat 16.
4. `tl_a_ready` held 0 for 5 cycles while req1 raises valid -> source stays 0 and the address stays stable until the fire.
5. D beat with source 1, none outstanding -> `tl_d_ready`=1, no `rsp_valid`, `protocol_err`=1 until reset.
6. Size 0 at addr 0x...3 -> mask 4'b1000; size 1 at addr 0x...2 -> mask 4'b1100.

Source files
------------

// File: rtl/instruction_tl_arbiter_pkg.sv
// TileLink-UL opcodes and mask/beat helpers shared by the instruction-port arbiter.
package instruction_tl_pkg;
    localparam logic [2:0] TL_OP_GET             = 3'd4;
    localparam logic [2:0] TL_OP_ACCESS_ACK_DATA = 3'd1;
    localparam int         LG_BEAT               = 2;
    localparam int         BEAT_CNT_W            = 16;

    function automatic logic [3:0] tl_mask(input logic [3:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        if (size >= 4'd2)
            m = 4'hF;
        else if (size == 4'd1)
            m = addr_lo[1] ? 4'b1100 : 4'b0011;
        else
            m = 4'b0001 << addr_lo;
        return m;
    endfunction

    // Remaining beats after the first; oversize requests still get a full count.
    function automatic logic [BEAT_CNT_W-1:0] tl_beats_m1(input logic [3:0] size);
        logic [BEAT_CNT_W-1:0] n;
        if (size > 4'(LG_BEAT))
            n = (BEAT_CNT_W'(1) << (size - 4'(LG_BEAT))) - BEAT_CNT_W'(1);
        else
            n = '0;
        return n;
    endfunction
endpackage

// File: rtl/instruction_tl_arbiter_if.sv
// Requester-side and TileLink-side signals of the instruction-port arbiter.
interface instruction_tl_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*ADDR_W-1:0] req_address;
    logic [7:0]          req_size;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_denied;
    logic                rsp_corrupt;
    logic                rsp_last;

    logic                tl_a_valid;
    logic                tl_a_ready;
    logic [2:0]          tl_a_opcode;
    logic [2:0]          tl_a_param;
    logic [3:0]          tl_a_size;
    logic                tl_a_source;
    logic [ADDR_W-1:0]   tl_a_address;
    logic [DATA_W/8-1:0] tl_a_mask;

    logic                tl_d_valid;
    logic                tl_d_ready;
    logic [2:0]          tl_d_opcode;
    logic [1:0]          tl_d_param;
    logic [3:0]          tl_d_size;
    logic                tl_d_source;
    logic                tl_d_sink;
    logic                tl_d_denied;
    logic                tl_d_corrupt;
    logic [DATA_W-1:0]   tl_d_data;

    modport master (
        input  req_valid, req_address, req_size, rsp_ready,
        input  tl_a_ready,
        input  tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
        input  tl_d_sink, tl_d_denied, tl_d_corrupt, tl_d_data,
        output req_ready, rsp_valid, rsp_data, rsp_denied, rsp_corrupt, rsp_last,
        output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
        output tl_a_address, tl_a_mask, tl_d_ready
    );

    modport slave (
        output req_valid, req_address, req_size, rsp_ready,
        output tl_a_ready,
        output tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
        output tl_d_sink, tl_d_denied, tl_d_corrupt, tl_d_data,
        input  req_ready, rsp_valid, rsp_data, rsp_denied, rsp_corrupt, rsp_last,
        input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
        input  tl_a_address, tl_a_mask, tl_d_ready
    );
endinterface

// File: rtl/instruction_tl_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a stalled grant is frozen until it fires.
module instruction_tl_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_eligible,
    input  logic       i_lock,
    input  logic       i_fire,
    output logic       o_valid,
    output logic       o_grant
);
    logic r_rr;
    logic r_locked;
    logic r_lockGrant;
    logic w_pick;

    always_comb begin
        w_pick = r_rr;
        if (i_eligible[r_rr])
            w_pick = r_rr;
        else if (i_eligible[~r_rr])
            w_pick = ~r_rr;
        o_grant = r_locked ? r_lockGrant : w_pick;
        o_valid = r_locked | (|i_eligible);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr        <= 1'b0;
            r_locked    <= 1'b0;
            r_lockGrant <= 1'b0;
        end else if (i_fire) begin
            r_rr     <= ~o_grant;
            r_locked <= 1'b0;
        end else if (i_lock) begin
            r_locked    <= 1'b1;
            r_lockGrant <= o_grant;
        end
    end
endmodule

// File: rtl/instruction_tl_arbiter.sv
// Shares the hart-0 instruction TileLink-UL port between the fetch unit and the debug fetch path.
// Optional perf counters are enabled with INSTRUCTION_TL_ARBITER_PERF_EN.
module instruction_tl_arbiter
    import instruction_tl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_tl_arbiter_if.master   bus,
`ifdef INSTRUCTION_TL_ARBITER_PERF_EN
    output logic [31:0]                perf_grant0,
    output logic [31:0]                perf_grant1,
    output logic [31:0]                perf_denied,
`endif
    output logic                       protocol_err
);
    logic [1:0]            r_outstanding;
    logic [BEAT_CNT_W-1:0] r_beatCnt [2];
    logic                  r_protocolErr;
    logic [1:0]            w_eligible;
    logic                  w_grantValid;
    logic                  w_grant;
    logic                  w_aFire;
    logic [3:0]            w_aSize;
    logic [ADDR_W-1:0]     w_aAddr;
    logic                  w_src;
    logic                  w_dOwned;
    logic                  w_dFire;
    logic                  w_dLast;
    logic                  w_unused;

    assign w_eligible = bus.req_valid & ~r_outstanding;

    instruction_tl_rr_arb2 u_arb (
        .clock      (clock),
        .reset      (reset),
        .i_eligible (w_eligible),
        .i_lock     (w_grantValid & ~bus.tl_a_ready),
        .i_fire     (w_aFire),
        .o_valid    (w_grantValid),
        .o_grant    (w_grant)
    );

    assign w_aSize = w_grant ? bus.req_size[7:4] : bus.req_size[3:0];
    assign w_aAddr = w_grant ? bus.req_address[2*ADDR_W-1:ADDR_W] : bus.req_address[ADDR_W-1:0];
    assign w_aFire = w_grantValid & bus.tl_a_ready;

    assign bus.tl_a_valid   = w_grantValid;
    assign bus.tl_a_opcode  = TL_OP_GET;
    assign bus.tl_a_param   = 3'd0;
    assign bus.tl_a_size    = w_aSize;
    assign bus.tl_a_source  = w_grant;
    assign bus.tl_a_address = w_aAddr;
    assign bus.tl_a_mask    = tl_mask(w_aSize, w_aAddr[1:0]);

    assign w_src    = bus.tl_d_source;
    assign w_dOwned = r_outstanding[w_src] && (bus.tl_d_opcode == TL_OP_ACCESS_ACK_DATA);
    assign w_dFire  = bus.tl_d_valid & bus.tl_d_ready;
    assign w_dLast  = (r_beatCnt[w_src] == '0);

    // Beats nobody is waiting for are swallowed so the D channel never wedges.
    always_comb begin
        bus.req_ready  = 2'b00;
        bus.rsp_valid  = 2'b00;
        bus.tl_d_ready = 1'b1;
        if (w_aFire)
            bus.req_ready[w_grant] = 1'b1;
        if (w_dOwned) begin
            bus.rsp_valid[w_src] = bus.tl_d_valid;
            bus.tl_d_ready       = bus.rsp_ready[w_src];
        end
    end

    assign bus.rsp_data    = bus.tl_d_data;
    assign bus.rsp_denied  = bus.tl_d_denied;
    assign bus.rsp_corrupt = bus.tl_d_corrupt;
    assign bus.rsp_last    = w_dLast;
    assign protocol_err    = r_protocolErr;
    assign w_unused        = ^{bus.tl_d_param, bus.tl_d_size, bus.tl_d_sink};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_outstanding <= 2'b00;
            r_beatCnt[0]  <= '0;
            r_beatCnt[1]  <= '0;
            r_protocolErr <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_aFire && (w_grant == 1'(i))) begin
                    r_outstanding[i] <= 1'b1;
                    r_beatCnt[i]     <= tl_beats_m1(w_aSize);
                end else if (w_dFire && w_dOwned && (w_src == 1'(i))) begin
                    if (r_beatCnt[i] == '0)
                        r_outstanding[i] <= 1'b0;
                    else
                        r_beatCnt[i] <= r_beatCnt[i] - 1'b1;
                end
            end
            if ((w_dFire && !w_dOwned) || (w_aFire && (w_aSize > 4'(MAX_SIZE))))
                r_protocolErr <= 1'b1;
        end
    end

`ifdef INSTRUCTION_TL_ARBITER_PERF_EN
    logic [31:0] r_perfGrant0;
    logic [31:0] r_perfGrant1;
    logic [31:0] r_perfDenied;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perfGrant0 <= '0;
            r_perfGrant1 <= '0;
            r_perfDenied <= '0;
        end else begin
            if (w_aFire && !w_grant && (r_perfGrant0 != 32'hFFFF_FFFF))
                r_perfGrant0 <= r_perfGrant0 + 32'd1;
            if (w_aFire && w_grant && (r_perfGrant1 != 32'hFFFF_FFFF))
                r_perfGrant1 <= r_perfGrant1 + 32'd1;
            if (w_dFire && w_dOwned && w_dLast && bus.tl_d_denied && (r_perfDenied != 32'hFFFF_FFFF))
                r_perfDenied <= r_perfDenied + 32'd1;
        end
    end

    assign perf_grant0 = r_perfGrant0;
    assign perf_grant1 = r_perfGrant1;
    assign perf_denied = r_perfDenied;
`endif
endmodule

// File: tb/tb_instruction_tl_arbiter.sv
// Directed testbench for instruction_tl_arbiter: grant order, locking, masks, bursts and drain path.
module tb_instruction_tl_arbiter;
    import instruction_tl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    instruction_tl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef INSTRUCTION_TL_ARBITER_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_denied;
`endif
    logic protocol_err;

    instruction_tl_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_SIZE(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
`ifdef INSTRUCTION_TL_ARBITER_PERF_EN
        .perf_grant0  (perf_grant0),
        .perf_grant1  (perf_grant1),
        .perf_denied  (perf_denied),
`endif
        .protocol_err (protocol_err)
    );

    task automatic driveD(input logic v, input logic src, input logic [2:0] op, input logic [31:0] data);
        bus.tl_d_valid   = v;
        bus.tl_d_source  = src;
        bus.tl_d_opcode  = op;
        bus.tl_d_data    = data;
        bus.tl_d_param   = 2'd0;
        bus.tl_d_size    = 4'd2;
        bus.tl_d_sink    = 1'b0;
        bus.tl_d_denied  = 1'b0;
        bus.tl_d_corrupt = 1'b0;
    endtask

    task automatic applyReset;
        @(negedge clock);
        bus.req_valid   = 2'b00;
        bus.req_address = '0;
        bus.req_size    = '0;
        bus.rsp_ready   = 2'b00;
        bus.tl_a_ready  = 1'b0;
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        applyReset;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 00", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.tl_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_valid got %b exp 0", bus.tl_a_valid); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_protocol_err got %b exp 0", protocol_err); end
        checks++; if (bus.tl_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_d_ready got %b exp 1", bus.tl_d_ready); end
    endtask

    task automatic test_single;
        applyReset;
        bus.req_valid   = 2'b01;
        bus.req_address = {32'h0, 32'h8000_0000};
        bus.req_size    = {4'd0, 4'd2};
        bus.tl_a_ready  = 1'b1;
        #1;
        checks++; if (bus.tl_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_a_valid got %b exp 1", bus.tl_a_valid); end
        checks++; if (bus.tl_a_opcode !== 3'd4) begin errors++; $display("[TB] FAIL single_opcode got %0d exp 4", bus.tl_a_opcode); end
        checks++; if (bus.tl_a_param !== 3'd0) begin errors++; $display("[TB] FAIL single_param got %0d exp 0", bus.tl_a_param); end
        checks++; if (bus.tl_a_source !== 1'b0) begin errors++; $display("[TB] FAIL single_source got %b exp 0", bus.tl_a_source); end
        checks++; if (bus.tl_a_mask !== 4'hF) begin errors++; $display("[TB] FAIL single_mask got %h exp f", bus.tl_a_mask); end
        checks++; if (bus.tl_a_address !== 32'h8000_0000) begin errors++; $display("[TB] FAIL single_address got %h exp 80000000", bus.tl_a_address); end
        checks++; if (bus.tl_a_size !== 4'd2) begin errors++; $display("[TB] FAIL single_size got %0d exp 2", bus.tl_a_size); end
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_req_ready got %b exp 01", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        driveD(1'b1, 1'b0, TL_OP_ACCESS_ACK_DATA, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid got %b exp 01", bus.rsp_valid); end
        checks++; if (bus.rsp_last !== 1'b1) begin errors++; $display("[TB] FAIL single_rsp_last got %b exp 1", bus.rsp_last); end
        checks++; if (bus.rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_rsp_data got %h exp deadbeef", bus.rsp_data); end
        checks++; if (bus.tl_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_d_ready got %b exp 1", bus.tl_d_ready); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        bus.req_valid  = 2'b01;
        bus.tl_a_ready = 1'b0;
        #1;
        checks++; if (bus.tl_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_outstanding_cleared got %b exp 1", bus.tl_a_valid); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL single_protocol_err got %b exp 0", protocol_err); end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_alternate;
        logic       exp;
        logic       prev;
        logic [1:0] expBits;
        applyReset;
        bus.rsp_ready   = 2'b11;
        bus.tl_a_ready  = 1'b1;
        bus.req_valid   = 2'b11;
        bus.req_address = {32'h0000_2000, 32'h0000_1000};
        bus.req_size    = {4'd2, 4'd2};
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2) == 1;
            if (k > 0) driveD(1'b1, prev, TL_OP_ACCESS_ACK_DATA, 32'h100 + k);
            #1;
            expBits = 2'b01 << exp;
            checks++; if (bus.tl_a_source !== exp) begin errors++; $display("[TB] FAIL alt_source[%0d] got %b exp %b", k, bus.tl_a_source, exp); end
            checks++; if (bus.req_ready !== expBits) begin errors++; $display("[TB] FAIL alt_req_ready[%0d] got %b exp %b", k, bus.req_ready, expBits); end
            if (k > 0) begin
                expBits = 2'b01 << prev;
                checks++; if (bus.rsp_valid !== expBits) begin errors++; $display("[TB] FAIL alt_rsp_valid[%0d] got %b exp %b", k, bus.rsp_valid, expBits); end
            end
            prev = exp;
            @(negedge clock);
        end
        bus.req_valid = 2'b00;
        driveD(1'b1, 1'b1, TL_OP_ACCESS_ACK_DATA, 32'h200);
        #1;
        checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL alt_final_rsp got %b exp 10", bus.rsp_valid); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL alt_protocol_err got %b exp 0", protocol_err); end
`ifdef INSTRUCTION_TL_ARBITER_PERF_EN
        checks++; if (perf_grant0 !== 32'd2) begin errors++; $display("[TB] FAIL perf_grant0 got %0d exp 2", perf_grant0); end
        checks++; if (perf_grant1 !== 32'd2) begin errors++; $display("[TB] FAIL perf_grant1 got %0d exp 2", perf_grant1); end
`endif
    endtask

    task automatic test_burst;
        logic expLast;
        applyReset;
        bus.req_valid   = 2'b10;
        bus.req_address = {32'h1000_0040, 32'h0};
        bus.req_size    = {4'd6, 4'd0};
        bus.tl_a_ready  = 1'b1;
        bus.rsp_ready   = 2'b10;
        #1;
        checks++; if (bus.tl_a_source !== 1'b1) begin errors++; $display("[TB] FAIL burst_source got %b exp 1", bus.tl_a_source); end
        checks++; if (bus.tl_a_size !== 4'd6) begin errors++; $display("[TB] FAIL burst_size got %0d exp 6", bus.tl_a_size); end
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL burst_req_ready got %b exp 10", bus.req_ready); end
        @(negedge clock);
        for (int b = 0; b < 16; b++) begin
            driveD(1'b1, 1'b1, TL_OP_ACCESS_ACK_DATA, 32'hA000_0000 + b);
            #1;
            expLast = (b == 15);
            checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL burst_rsp_valid[%0d] got %b exp 10", b, bus.rsp_valid); end
            checks++; if (bus.rsp_last !== expLast) begin errors++; $display("[TB] FAIL burst_rsp_last[%0d] got %b exp %b", b, bus.rsp_last, expLast); end
            checks++; if (bus.tl_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_resubmit_blocked[%0d] got %b exp 0", b, bus.tl_a_valid); end
            @(negedge clock);
        end
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        checks++; if (bus.tl_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL burst_resubmit_open got %b exp 1", bus.tl_a_valid); end
        checks++; if (bus.tl_a_source !== 1'b1) begin errors++; $display("[TB] FAIL burst_resubmit_source got %b exp 1", bus.tl_a_source); end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_lock;
        applyReset;
        bus.rsp_ready   = 2'b11;
        bus.tl_a_ready  = 1'b1;
        bus.req_valid   = 2'b01;
        bus.req_address = {32'h0, 32'h2000_0000};
        bus.req_size    = {4'd0, 4'd2};
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL lock_setup_fire got %b exp 01", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        driveD(1'b1, 1'b0, TL_OP_ACCESS_ACK_DATA, 32'h0);
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        bus.req_valid   = 2'b01;
        bus.req_address = {32'h3000_0000, 32'h2000_0010};
        bus.req_size    = {4'd2, 4'd3};
        bus.tl_a_ready  = 1'b0;
        #1;
        checks++; if (bus.tl_a_source !== 1'b0) begin errors++; $display("[TB] FAIL lock_initial_source got %b exp 0", bus.tl_a_source); end
        @(negedge clock);
        bus.req_valid = 2'b11;
        for (int c = 1; c < 5; c++) begin
            #1;
            checks++; if (bus.tl_a_source !== 1'b0) begin errors++; $display("[TB] FAIL lock_source[%0d] got %b exp 0", c, bus.tl_a_source); end
            checks++; if (bus.tl_a_address !== 32'h2000_0010) begin errors++; $display("[TB] FAIL lock_address[%0d] got %h exp 20000010", c, bus.tl_a_address); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL lock_req_ready[%0d] got %b exp 00", c, bus.req_ready); end
            @(negedge clock);
        end
        bus.tl_a_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL lock_fire got %b exp 01", bus.req_ready); end
        checks++; if (bus.tl_a_mask !== 4'hF) begin errors++; $display("[TB] FAIL lock_mask got %h exp f", bus.tl_a_mask); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        driveD(1'b1, 1'b0, TL_OP_ACCESS_ACK_DATA, 32'h11);
        #1;
        checks++; if (bus.rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL lock_beat0_last got %b exp 0", bus.rsp_last); end
        @(negedge clock);
        driveD(1'b1, 1'b0, TL_OP_ACCESS_ACK_DATA, 32'h22);
        #1;
        checks++; if (bus.rsp_last !== 1'b1) begin errors++; $display("[TB] FAIL lock_beat1_last got %b exp 1", bus.rsp_last); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic test_mask;
        logic [3:0] sizes [5]   = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd2};
        logic [1:0] addrLo [5]  = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1};
        logic [3:0] expMask [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
        applyReset;
        bus.tl_a_ready = 1'b0;
        bus.req_valid  = 2'b01;
        for (int v = 0; v < 5; v++) begin
            bus.req_address = {32'h0, 30'h1000_0000, addrLo[v]};
            bus.req_size    = {4'd0, sizes[v]};
            #1;
            checks++; if (bus.tl_a_mask !== expMask[v]) begin errors++; $display("[TB] FAIL mask[%0d] got %b exp %b", v, bus.tl_a_mask, expMask[v]); end
            @(negedge clock);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_drain;
        applyReset;
        bus.rsp_ready = 2'b11;
        driveD(1'b1, 1'b1, TL_OP_ACCESS_ACK_DATA, 32'h5555_5555);
        #1;
        checks++; if (bus.tl_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_d_ready got %b exp 1", bus.tl_d_ready); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL drain_rsp_valid got %b exp 00", bus.rsp_valid); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL drain_err_set got %b exp 1", protocol_err); end
        repeat (3) @(negedge clock);
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL drain_err_sticky got %b exp 1", protocol_err); end
        applyReset;
        #1;
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL drain_err_cleared got %b exp 0", protocol_err); end
        bus.req_valid   = 2'b01;
        bus.req_address = {32'h0, 32'h4000_0000};
        bus.req_size    = {4'd0, 4'd2};
        bus.tl_a_ready  = 1'b1;
        @(negedge clock);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        driveD(1'b1, 1'b0, 3'd0, 32'h0);
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL badop_rsp_valid got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.tl_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL badop_d_ready got %b exp 1", bus.tl_d_ready); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL badop_err got %b exp 1", protocol_err); end
    endtask

    task automatic test_oversize;
        applyReset;
        bus.req_valid   = 2'b01;
        bus.req_address = {32'h0, 32'h0000_0000};
        bus.req_size    = {4'd0, 4'd7};
        bus.tl_a_ready  = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL oversize_forwarded got %b exp 01", bus.req_ready); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL oversize_err_before got %b exp 0", protocol_err); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        #1;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL oversize_err got %b exp 1", protocol_err); end
    endtask

    task automatic test_reset_mid;
        applyReset;
        bus.req_valid   = 2'b10;
        bus.req_address = {32'h1000_0000, 32'h0};
        bus.req_size    = {4'd6, 4'd0};
        bus.tl_a_ready  = 1'b1;
        bus.rsp_ready   = 2'b10;
        @(negedge clock);
        bus.req_valid = 2'b00;
        for (int b = 0; b < 3; b++) begin
            driveD(1'b1, 1'b1, TL_OP_ACCESS_ACK_DATA, 32'h77 + b);
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.rsp_ready = 2'b00;
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL midreset_rsp_valid got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.tl_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_d_ready got %b exp 1", bus.tl_d_ready); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err_before got %b exp 0", protocol_err); end
        @(negedge clock);
        driveD(1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL midreset_stale_err got %b exp 1", protocol_err); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_alternate;
        test_burst;
        test_lock;
        test_mask;
        test_drain;
        test_oversize;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
